ep_mem_sched: RTL and testbench

- Single-owner scheduler for the Enterprise SDRAM port.
- Sequences the power-on boot-ROM copy into SDRAM, then arbitrates four requesters: refresh, HPS ROM download, CPU memory and the idle slot.
- Applies page-permission decode (RAM size, ROM top, VRAM pages) before issuing commands.
- Sits between the ep core, the HPS ioctl interface and the sdram controller; one command is outstanding at a time.

---
 rtl/ep_mem_pkg.sv | 39 +++
 rtl/ep_mem_decode.sv | 24 ++
 rtl/ep_mem_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_ep_mem_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ep_mem_pkg.sv
// Shared types and helpers for the Enterprise SDRAM scheduler.
// Holds the FSM states, command tags and page-map constants.
package ep_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT_RD,
        INIT_WR,
        WAIT_ACK
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INIT,
        OP_RFSH,
        OP_DL,
        OP_CPU_RD,
        OP_CPU_WR
    } op_t;

    localparam logic [7:0] VMM_PAGE    = 8'hFC;
    localparam logic [7:0] ROM_WR_PAGE = 8'h07;

    // Lowest RAM page for each RAM size; unknown sizes fall back to 1MB.
    function automatic logic [7:0] maxram(input logic [2:0] sel);
        logic [7:0] m;
        case (sel)
            3'd1:    m = 8'h80;
            3'd2:    m = 8'h40;
            3'd3:    m = 8'hFC;
            3'd4:    m = 8'hF8;
            3'd5:    m = 8'hF0;
            3'd6:    m = 8'hE0;
            default: m = 8'hC0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ep_mem_decode.sv
// Page permission decode for CPU accesses.
// Pure combinational: RAM, ROM, VRAM and write-enable flags.
module ep_mem_decode
    import ep_mem_pkg::*;
(
    input  logic [7:0] page,
    input  logic       a13,
    input  logic [2:0] ramSel,
    input  logic [7:0] romTop,
    output logic       ram,
    output logic       rom,
    output logic       vmm,
    output logic       wrOk
);

    // Classify the page against the configured memory map.
    always_comb begin
        ram  = page >= maxram(ramSel);
        rom  = page <= romTop;
        vmm  = page >= VMM_PAGE;
        wrOk = ram | ((page == ROM_WR_PAGE) & a13);
    end

endmodule

// File: rtl/ep_mem_sched.sv
// Single-owner scheduler for the Enterprise SDRAM port.
// Boot-ROM copy, then refresh > download > CPU, one command in flight.
module ep_mem_sched
    import ep_mem_pkg::*;
#(
    parameter int unsigned INIT_WORDS  = 131072,
    parameter int unsigned INIT_AW     = 17,
    parameter logic [7:0]  ROM_TOP_RST = 8'h07
) (
    input  logic               clock32,
    input  logic               reset,
    input  logic               sdrReady,
    output logic [INIT_AW-1:0] iniA,
    input  logic [7:0]         iniD,
    output logic               iniDone,
    input  logic               dlIo,
    input  logic [21:0]        dlA,
    input  logic [7:0]         dlD,
    input  logic               dlW,
    output logic               dlWait,
    input  logic [21:0]        cpuA,
    input  logic [7:0]         cpuD,
    input  logic               cpuR,
    input  logic               cpuW,
    output logic [7:0]         cpuQ,
    output logic               cpuAck,
    input  logic [2:0]         ramSel,
    output logic [7:0]         romTop,
    output logic               vmmW,
    input  logic               rfshReq,
    output logic               sdrRd,
    output logic               sdrWr,
    output logic               sdrRf,
    output logic [24:0]        sdrA,
    output logic [15:0]        sdrD,
    input  logic [15:0]        sdrQ,
    input  logic               sdrAck
);

    localparam logic [INIT_AW-1:0] INI_LAST = INIT_AW'(INIT_WORDS - 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [INIT_AW-1:0] ini_a_q, ini_a_d;
    logic               ini_done_q, ini_done_d;
    logic [1:0]         rfsh_q, rfsh_d;
    logic               dl_pend_q, dl_pend_d;
    logic               dl_busy_q, dl_busy_d;
    logic [21:0]        dl_a_q, dl_a_d;
    logic [7:0]         dl_d_q, dl_d_d;
    logic               cpu_pend_q, cpu_pend_d;
    logic               cpu_rd_q, cpu_rd_d;
    logic [21:0]        cpu_a_q, cpu_a_d;
    logic [7:0]         cpu_d_q, cpu_d_d;
    logic [7:0]         cpu_q_q, cpu_q_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic [7:0]         rom_top_q, rom_top_d;
    logic               vmm_w_q, vmm_w_d;
    logic               sdr_rd_q, sdr_rd_d;
    logic               sdr_wr_q, sdr_wr_d;
    logic               sdr_rf_q, sdr_rf_d;
    logic [24:0]        sdr_a_q, sdr_a_d;
    logic [15:0]        sdr_d_q, sdr_d_d;
    logic               rfsh_svc, rfsh_inc;
    logic               dec_ram, dec_rom, dec_vmm, dec_wr_ok;
    logic               unused_hi;

    assign unused_hi = &{1'b0, sdrQ[15:8]};

    ep_mem_decode u_decode (
        .page   (cpu_a_q[21:14]),
        .a13    (cpu_a_q[13]),
        .ramSel (ramSel),
        .romTop (rom_top_q),
        .ram    (dec_ram),
        .rom    (dec_rom),
        .vmm    (dec_vmm),
        .wrOk   (dec_wr_ok)
    );

    // Arbitration, command issue, ack handling and request capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ini_a_d    = ini_a_q;
        ini_done_d = ini_done_q;
        dl_pend_d  = dl_pend_q;
        dl_busy_d  = dl_busy_q;
        dl_a_d     = dl_a_q;
        dl_d_d     = dl_d_q;
        cpu_pend_d = cpu_pend_q;
        cpu_rd_d   = cpu_rd_q;
        cpu_a_d    = cpu_a_q;
        cpu_d_d    = cpu_d_q;
        cpu_q_d    = cpu_q_q;
        rom_top_d  = rom_top_q;
        sdr_a_d    = sdr_a_q;
        sdr_d_d    = sdr_d_q;
        cpu_ack_d  = 1'b0;
        vmm_w_d    = 1'b0;
        sdr_rd_d   = 1'b0;
        sdr_wr_d   = 1'b0;
        sdr_rf_d   = 1'b0;
        rfsh_svc   = 1'b0;
        rfsh_d     = rfsh_q;

        unique case (state_q)
            IDLE: begin
                if (sdrReady) begin
                    if (rfsh_q != 2'd0) begin
                        sdr_rf_d = 1'b1;
                        rfsh_svc = 1'b1;
                        op_d     = OP_RFSH;
                        state_d  = WAIT_ACK;
                    end else if (!ini_done_q) begin
                        state_d = INIT_RD;
                    end else if (dl_pend_q) begin
                        sdr_wr_d  = 1'b1;
                        sdr_a_d   = 25'(dl_a_q);
                        sdr_d_d   = {8'd0, dl_d_q};
                        dl_pend_d = 1'b0;
                        op_d      = OP_DL;
                        state_d   = WAIT_ACK;
                    end else if (cpu_pend_q) begin
                        cpu_pend_d = 1'b0;
                        vmm_w_d    = !cpu_rd_q && dec_vmm;
                        if (cpu_rd_q && (dec_ram || dec_rom)) begin
                            sdr_rd_d = 1'b1;
                            sdr_a_d  = 25'(cpu_a_q);
                            op_d     = OP_CPU_RD;
                            state_d  = WAIT_ACK;
                        end else if (!cpu_rd_q && dec_wr_ok) begin
                            sdr_wr_d = 1'b1;
                            sdr_a_d  = 25'(cpu_a_q);
                            sdr_d_d  = {8'd0, cpu_d_q};
                            op_d     = OP_CPU_WR;
                            state_d  = WAIT_ACK;
                        end else begin
                            cpu_ack_d = 1'b1;
                            if (cpu_rd_q) cpu_q_d = 8'hFF;
                        end
                    end
                end
            end
            INIT_RD: state_d = INIT_WR;
            INIT_WR: begin
                sdr_wr_d = 1'b1;
                sdr_a_d  = 25'(ini_a_q);
                sdr_d_d  = {8'd0, iniD};
                op_d     = OP_INIT;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (sdrAck) begin
                    state_d = IDLE;
                    op_d    = OP_NONE;
                    case (op_q)
                        OP_INIT: begin
                            ini_a_d = ini_a_q + 1'b1;
                            if (ini_a_q == INI_LAST) ini_done_d = 1'b1;
                        end
                        OP_DL: if (!dl_pend_q) dl_busy_d = 1'b0;
                        OP_CPU_RD: begin
                            cpu_q_d   = sdrQ[7:0];
                            cpu_ack_d = 1'b1;
                        end
                        OP_CPU_WR: cpu_ack_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // A request at a full counter is dropped unless one is served now.
        rfsh_inc = rfshReq && ((rfsh_q != 2'd3) || rfsh_svc);
        if (rfsh_inc && !rfsh_svc) rfsh_d = rfsh_q + 2'd1;
        else if (!rfsh_inc && rfsh_svc) rfsh_d = rfsh_q - 2'd1;

        if (dlW) begin
            dl_pend_d = 1'b1;
            dl_busy_d = 1'b1;
            dl_a_d    = dlA;
            dl_d_d    = dlD;
            rom_top_d = {2'b00, dlA[19:14]};
        end
        if (cpuR || cpuW) begin
            cpu_pend_d = 1'b1;
            cpu_rd_d   = cpuR;
            cpu_a_d    = cpuA;
            cpu_d_d    = cpuD;
        end
    end

    // State register; reset abandons any command in flight.
    always_ff @(posedge clock32) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_NONE;
            ini_a_q    <= '0;
            ini_done_q <= 1'b0;
            rfsh_q     <= 2'd0;
            dl_pend_q  <= 1'b0;
            dl_busy_q  <= 1'b0;
            dl_a_q     <= '0;
            dl_d_q     <= '0;
            cpu_pend_q <= 1'b0;
            cpu_rd_q   <= 1'b0;
            cpu_a_q    <= '0;
            cpu_d_q    <= '0;
            cpu_q_q    <= 8'hFF;
            cpu_ack_q  <= 1'b0;
            rom_top_q  <= ROM_TOP_RST;
            vmm_w_q    <= 1'b0;
            sdr_rd_q   <= 1'b0;
            sdr_wr_q   <= 1'b0;
            sdr_rf_q   <= 1'b0;
            sdr_a_q    <= '0;
            sdr_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ini_a_q    <= ini_a_d;
            ini_done_q <= ini_done_d;
            rfsh_q     <= rfsh_d;
            dl_pend_q  <= dl_pend_d;
            dl_busy_q  <= dl_busy_d;
            dl_a_q     <= dl_a_d;
            dl_d_q     <= dl_d_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_rd_q   <= cpu_rd_d;
            cpu_a_q    <= cpu_a_d;
            cpu_d_q    <= cpu_d_d;
            cpu_q_q    <= cpu_q_d;
            cpu_ack_q  <= cpu_ack_d;
            rom_top_q  <= rom_top_d;
            vmm_w_q    <= vmm_w_d;
            sdr_rd_q   <= sdr_rd_d;
            sdr_wr_q   <= sdr_wr_d;
            sdr_rf_q   <= sdr_rf_d;
            sdr_a_q    <= sdr_a_d;
            sdr_d_q    <= sdr_d_d;
        end
    end

    assign iniA    = ini_a_q;
    assign iniDone = ini_done_q;
    assign dlWait  = dl_busy_q | (dlIo & ~ini_done_q);
    assign cpuQ    = cpu_q_q;
    assign cpuAck  = cpu_ack_q;
    assign romTop  = rom_top_q;
    assign vmmW    = vmm_w_q;
    assign sdrRd   = sdr_rd_q;
    assign sdrWr   = sdr_wr_q;
    assign sdrRf   = sdr_rf_q;
    assign sdrA    = sdr_a_q;
    assign sdrD    = sdr_d_q;

endmodule

// File: tb/tb_ep_mem_sched.sv
// Directed bench for ep_mem_sched with command and ack scoreboards.
// SDRAM model acks each command 3 cycles after its strobe.
module tb_ep_mem_sched;

    localparam int IW = 16;
    localparam logic [2:0] K_RD = 3'b100;
    localparam logic [2:0] K_WR = 3'b010;
    localparam logic [2:0] K_RF = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [24:0] addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic       rd;
        logic [7:0] q;
    } ack_t;

    logic        clock32 = 1'b0;
    logic        reset = 1'b1;
    logic        sdrReady = 1'b0;
    logic [16:0] iniA;
    logic [7:0]  iniD = 8'h00;
    logic        iniDone;
    logic        dlIo = 1'b0;
    logic [21:0] dlA = '0;
    logic [7:0]  dlD = '0;
    logic        dlW = 1'b0;
    logic        dlWait;
    logic [21:0] cpuA = '0;
    logic [7:0]  cpuD = '0;
    logic        cpuR = 1'b0;
    logic        cpuW = 1'b0;
    logic [7:0]  cpuQ;
    logic        cpuAck;
    logic [2:0]  ramSel = 3'd0;
    logic [7:0]  romTop;
    logic        vmmW;
    logic        rfshReq = 1'b0;
    logic        sdrRd, sdrWr, sdrRf;
    logic [24:0] sdrA;
    logic [15:0] sdrD;
    logic [15:0] sdrQ = '0;
    logic        sdrAck = 1'b0;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];
    cmd_t oc;
    ack_t oa;
    int   checks = 0;
    int   errors = 0;
    int   n_ack = 0;
    int   n_vmm = 0;
    int   acnt = 0;
    logic hold = 1'b0;

    ep_mem_sched #(
        .INIT_WORDS  (IW),
        .INIT_AW     (17),
        .ROM_TOP_RST (8'h07)
    ) dut (
        .clock32 (clock32), .reset (reset), .sdrReady (sdrReady),
        .iniA (iniA), .iniD (iniD), .iniDone (iniDone),
        .dlIo (dlIo), .dlA (dlA), .dlD (dlD), .dlW (dlW), .dlWait (dlWait),
        .cpuA (cpuA), .cpuD (cpuD), .cpuR (cpuR), .cpuW (cpuW),
        .cpuQ (cpuQ), .cpuAck (cpuAck), .ramSel (ramSel), .romTop (romTop),
        .vmmW (vmmW), .rfshReq (rfshReq), .sdrRd (sdrRd), .sdrWr (sdrWr),
        .sdrRf (sdrRf), .sdrA (sdrA), .sdrD (sdrD), .sdrQ (sdrQ),
        .sdrAck (sdrAck)
    );

    always #5 clock32 = ~clock32;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] fini(input logic [16:0] a);
        return a[7:0] * 8'd7 + 8'h03;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] k, input logic [24:0] a,
                            input logic [15:0] d);
        cmd_t c;
        c.kind = k;
        c.addr = a;
        c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_ack(input logic rd, input logic [7:0] q);
        ack_t a;
        a.rd = rd;
        a.q  = q;
        exp_ack.push_back(a);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock32);
        #1;
    endtask

    task automatic cpu(input logic rd, input logic [21:0] a,
                       input logic [7:0] d);
        cpuA = a;
        cpuD = d;
        cpuR = rd;
        cpuW = !rd;
        cyc(1);
        cpuR = 1'b0;
        cpuW = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int target,
                            input int budget);
        int k = 0;
        while (n_ack < target && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, n_ack, target);
    endtask

    task automatic wait_init();
        int k = 0;
        while (!iniDone && k < 400) begin
            cyc(1);
            k++;
        end
        chk("ini_done", iniDone, 1);
        chk("init_cmds_left", exp_cmd.size(), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_strobes", {sdrRd, sdrWr, sdrRf, cpuAck, vmmW}, 0);
        chk("rst_iniDone", iniDone, 0);
        chk("rst_dlWait", dlWait, 0);
        chk("rst_cpuQ", cpuQ, 8'hFF);
        chk("rst_romTop", romTop, 8'h07);
        chk("rst_iniA", iniA, 0);
        chk("rst_sdrA", sdrA, 0);
        chk("rst_sdrD", sdrD, 0);
    endtask

    task automatic push_init();
        for (int i = 0; i < IW; i++)
            push_cmd(K_WR, 25'(i), {8'h00, fini(17'(i))});
    endtask

    // Boot ROM: data follows the address one cycle later.
    always @(posedge clock32) begin
        #1;
        iniD = fini(iniA);
    end

    // SDRAM model: ack 3 cycles after a strobe unless held.
    always @(posedge clock32) begin
        #1;
        sdrAck = 1'b0;
        if (acnt > 0 && !hold) begin
            acnt--;
            if (acnt == 0) sdrAck = 1'b1;
        end
        if (sdrRd || sdrWr || sdrRf) acnt = 3;
    end

    // Scoreboard: compare commands and CPU acks as they appear.
    always @(negedge clock32) begin
        assert (!(cpuR && cpuW))
            else $error("protocol: cpuR and cpuW together");
        if (vmmW) n_vmm++;
        if (sdrRd || sdrWr || sdrRf) begin
            if (exp_cmd.size() == 0) begin
                chk("unexpected_cmd", {sdrRd, sdrWr, sdrRf}, 0);
            end else begin
                oc = exp_cmd.pop_front();
                chk("cmd_kind", {sdrRd, sdrWr, sdrRf}, oc.kind);
                chk("cmd_addr", sdrA, oc.addr);
                if (oc.kind == K_WR) chk("cmd_data", sdrD, oc.data);
            end
        end
        if (cpuAck) begin
            n_ack++;
            if (exp_ack.size() == 0) begin
                chk("spurious_ack", cpuAck, 0);
            end else begin
                oa = exp_ack.pop_front();
                if (oa.rd) chk("cpuQ", cpuQ, oa.q);
            end
        end
    end

    initial begin
        int t;
        int v;

        // Reset state and boot copy.
        cyc(3);
        check_reset_vals();
        push_init();
        reset = 1'b0;
        sdrReady = 1'b1;
        wait_init();
        cyc(2);

        // Read outside RAM/ROM: no SDRAM op, immediate FF.
        t = n_ack + 1;
        push_ack(1'b1, 8'hFF);
        cpu(1'b1, {8'h10, 14'h0123}, 8'h00);
        cyc(1);
        chk("nomem_ack_timing", cpuAck, 1);
        chk("nomem_cpuQ", cpuQ, 8'hFF);
        wait_ack("nomem_rd_ack", t, 10);

        // Read from RAM page C5.
        t = n_ack + 1;
        sdrQ = 16'h125A;
        push_cmd(K_RD, {3'b000, 8'hC5, 14'h0321}, 16'h0000);
        push_ack(1'b1, 8'h5A);
        cpu(1'b1, {8'hC5, 14'h0321}, 8'h00);
        wait_ack("ram_rd_ack", t, 30);

        // Write to ROM page 07 upper half.
        t = n_ack + 1;
        push_cmd(K_WR, {3'b000, 8'h07, 1'b1, 13'h0ABC}, 16'h005C);
        push_ack(1'b0, 8'h00);
        cpu(1'b0, {8'h07, 1'b1, 13'h0ABC}, 8'h5C);
        wait_ack("p07_wr_ack", t, 30);

        // Same page lower half: dropped.
        t = n_ack + 1;
        push_ack(1'b0, 8'h00);
        cpu(1'b0, {8'h07, 1'b0, 13'h0ABC}, 8'h5C);
        cyc(1);
        chk("drop_ack_timing", cpuAck, 1);
        wait_ack("drop_wr_ack", t, 10);

        // VRAM page write: vmmW plus SDRAM write.
        t = n_ack + 1;
        v = n_vmm + 1;
        push_cmd(K_WR, {3'b000, 8'hFE, 14'h0010}, 16'h00E7);
        push_ack(1'b0, 8'h00);
        cpu(1'b0, {8'hFE, 14'h0010}, 8'hE7);
        wait_ack("vmm_wr_ack", t, 30);
        chk("vmmW_pulses", n_vmm, v);

        // Download and CPU read together: download first.
        t = n_ack + 1;
        dlIo = 1'b1;
        sdrQ = 16'hAB3C;
        push_cmd(K_WR, {3'b000, 22'h028123}, 16'h0091);
        push_cmd(K_RD, {3'b000, 8'h09, 14'h0456}, 16'h0000);
        push_ack(1'b1, 8'h3C);
        dlA = 22'h028123;
        dlD = 8'h91;
        dlW = 1'b1;
        cpuA = {8'h09, 14'h0456};
        cpuR = 1'b1;
        cyc(1);
        dlW = 1'b0;
        cpuR = 1'b0;
        chk("dlWait_high", dlWait, 1);
        chk("romTop_dl", romTop, 8'h0A);
        wait_ack("dl_cpu_ack", t, 40);
        chk("dlWait_low", dlWait, 0);

        // Five refresh requests during a stalled download.
        t = n_ack + 1;
        hold = 1'b1;
        push_cmd(K_WR, {3'b000, 22'h028200}, 16'h0011);
        push_cmd(K_RF, 25'h0028200, 16'h0000);
        push_cmd(K_RF, 25'h0028200, 16'h0000);
        push_cmd(K_RF, 25'h0028200, 16'h0000);
        push_cmd(K_WR, {3'b000, 22'h028201}, 16'h0022);
        push_cmd(K_RD, {3'b000, 8'hC1, 14'h0007}, 16'h0000);
        push_ack(1'b1, 8'h3C);
        dlA = 22'h028200;
        dlD = 8'h11;
        dlW = 1'b1;
        cyc(1);
        dlW = 1'b0;
        cyc(2);
        repeat (5) begin
            rfshReq = 1'b1;
            cyc(1);
            rfshReq = 1'b0;
            cyc(1);
        end
        dlA = 22'h028201;
        dlD = 8'h22;
        dlW = 1'b1;
        cpuA = {8'hC1, 14'h0007};
        cpuR = 1'b1;
        cyc(1);
        dlW = 1'b0;
        cpuR = 1'b0;
        cyc(2);
        hold = 1'b0;
        wait_ack("rfsh_cpu_ack", t, 200);
        chk("rfsh_cmds_left", exp_cmd.size(), 0);
        dlIo = 1'b0;

        // Reset while a read waits for its ack.
        t = n_ack;
        hold = 1'b1;
        push_cmd(K_RD, {3'b000, 8'hC2, 14'h0001}, 16'h0000);
        cpu(1'b1, {8'hC2, 14'h0001}, 8'h00);
        cyc(3);
        chk("rd_issued", exp_cmd.size(), 0);
        reset = 1'b1;
        sdrReady = 1'b0;
        cyc(2);
        check_reset_vals();
        reset = 1'b0;
        hold = 1'b0;
        cyc(10);
        chk("late_ack_ignored", n_ack, t);
        chk("ini_restart", iniA, 0);
        push_init();
        sdrReady = 1'b1;
        wait_init();
        chk("acks_left", exp_ack.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
